// File: rtl/wb_rr_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant encodings,
// watchdog width and the round-robin pick function.
package wb_rr_arbiter2_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_e;

  localparam int WD_W = 16;

  // Tie goes to the master that was not served last.
  function automatic gnt_e pick_winner(input logic cyc0, input logic cyc1, input logic last);
    if (cyc0 && cyc1) return last ? GNT_M0 : GNT_M1;
    else if (cyc0) return GNT_M0;
    else if (cyc1) return GNT_M1;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transaction stall watchdog: counts unanswered strobe cycles and emits a
// one-cycle abort pulse when the count reaches the limit (limit 0 disables it).
module wb_arb_watchdog
  import wb_rr_arbiter2_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            stb,
  input  logic            ack,
  input  logic            err,
  input  logic [WD_W-1:0] limit,
  output logic            abort
);

  logic [WD_W-1:0] wd_reg, wd_next;
  logic            abort_reg, abort_next;

  always_comb begin
    wd_next    = '0;
    abort_next = 1'b0;
    if (limit != '0 && stb && !ack && !err) begin
      if (wd_reg == limit - 1'b1) abort_next = 1'b1;
      else wd_next = wd_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_reg    <= '0;
      abort_reg <= 1'b0;
    end else begin
      wd_reg    <= wd_next;
      abort_reg <= abort_next;
    end
  end

  assign abort = abort_reg;

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master round-robin Wishbone B3 classic arbiter with cyc-held ownership
// and a stall watchdog that aborts a hung slave cycle with err.
module wb_rr_arbiter2
  import wb_rr_arbiter2_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  input  logic            m0_we,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  output logic [DW-1:0]   m0_dat_r,
  output logic            m0_ack,
  output logic            m0_err,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  input  logic            m1_we,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  output logic [DW-1:0]   m1_dat_r,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  output logic            s_we,
  output logic            s_cyc,
  output logic            s_stb,
  input  logic [DW-1:0]   s_dat_r,
  input  logic            s_ack,
  input  logic            s_err,
  output logic [1:0]      gnt,
  output logic            timeout
);

  gnt_e       gnt_reg, gnt_next;
  logic       last_reg, last_next;
  logic       abort;
  logic [1:0] own;
  logic [1:0] req_cyc;
  logic       owner_cyc;
  logic       mux_cyc, mux_stb;
  logic [1:0] ack_v, err_v;

  assign own       = gnt_reg;
  assign req_cyc   = {m1_cyc, m0_cyc};
  assign owner_cyc = |(req_cyc & own);

  always_comb begin
    gnt_next  = gnt_reg;
    last_next = last_reg;
    if (abort) begin
      gnt_next = GNT_NONE;
    end else if (gnt_reg == GNT_NONE || !owner_cyc) begin
      gnt_next = pick_winner(m0_cyc, m1_cyc, last_reg);
      if (gnt_next == GNT_M0) last_next = 1'b0;
      else if (gnt_next == GNT_M1) last_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_reg  <= GNT_NONE;
      last_reg <= 1'b1;
    end else begin
      gnt_reg  <= gnt_next;
      last_reg <= last_next;
    end
  end

  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    mux_cyc = 1'b0;
    mux_stb = 1'b0;
    unique case (gnt_reg)
      GNT_M0: begin
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
        s_we    = m0_we;
        mux_cyc = m0_cyc;
        mux_stb = m0_stb;
      end
      GNT_M1: begin
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
        s_we    = m1_we;
        mux_cyc = m1_cyc;
        mux_stb = m1_stb;
      end
      default: ;
    endcase
  end

  // The abort cycle hides the bus from the slave, so a late ack is dropped.
  assign s_cyc = mux_cyc & ~abort;
  assign s_stb = mux_stb & ~abort;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign ack_v[gi] = own[gi] & s_ack & ~abort;
    assign err_v[gi] = own[gi] & (abort | s_err);
  end

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign m0_ack   = ack_v[0];
  assign m1_ack   = ack_v[1];
  assign m0_err   = err_v[0];
  assign m1_err   = err_v[1];
  assign gnt      = gnt_reg;
  assign timeout  = abort;

  wb_arb_watchdog u_watchdog (
    .clock (clock),
    .reset (reset),
    .stb   (s_stb),
    .ack   (s_ack),
    .err   (s_err),
    .limit (WD_W'(TIMEOUT)),
    .abort (abort)
  );

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Scoreboard bench for wb_rr_arbiter2: directed master sequences push expected
// responses per master; a negedge monitor pops and compares them.
module tb_wb_rr_arbiter2;

  localparam logic [31:0] PAT = 32'h5A5A_0000;
  localparam int SLV_WAIT = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] m_adr   [2];
  logic [31:0] m_dat_w [2];
  logic [3:0]  m_sel   [2];
  logic        m_we    [2];
  logic        m_cyc   [2];
  logic        m_stb   [2];

  logic [31:0] m0_dat_r, m1_dat_r, s_adr, s_dat_w, s_dat_r;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack, s_err, timeout;
  logic [1:0]  gnt;

  logic [31:0] d0_m0_dat_r, d0_m1_dat_r, d0_s_adr, d0_s_dat_w;
  logic        d0_m0_ack, d0_m0_err, d0_m1_ack, d0_m1_err;
  logic [3:0]  d0_s_sel;
  logic        d0_s_we, d0_s_cyc, d0_s_stb, d0_timeout;
  logic [1:0]  d0_gnt;

  // Slave model: acks after SLV_WAIT stalled cycles, data derived from address.
  logic slv_en;
  int   slv_cnt;
  assign s_ack   = slv_en && s_stb && (slv_cnt == SLV_WAIT);
  assign s_err   = 1'b0;
  assign s_dat_r = s_adr ^ PAT;
  always @(posedge clock) begin
    if (reset || !s_stb || s_ack) slv_cnt <= 0;
    else slv_cnt <= slv_cnt + 1;
  end

  wb_rr_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(8)) u_dut (
    .clock(clock), .reset(reset),
    .m0_adr(m_adr[0]), .m0_dat_w(m_dat_w[0]), .m0_sel(m_sel[0]), .m0_we(m_we[0]),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m_adr[1]), .m1_dat_w(m_dat_w[1]), .m1_sel(m_sel[1]), .m1_we(m_we[1]),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .gnt(gnt), .timeout(timeout)
  );

  wb_rr_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .m0_adr(m_adr[0]), .m0_dat_w(m_dat_w[0]), .m0_sel(m_sel[0]), .m0_we(m_we[0]),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_dat_r(d0_m0_dat_r), .m0_ack(d0_m0_ack), .m0_err(d0_m0_err),
    .m1_adr(m_adr[1]), .m1_dat_w(m_dat_w[1]), .m1_sel(m_sel[1]), .m1_we(m_we[1]),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_dat_r(d0_m1_dat_r), .m1_ack(d0_m1_ack), .m1_err(d0_m1_err),
    .s_adr(d0_s_adr), .s_dat_w(d0_s_dat_w), .s_sel(d0_s_sel), .s_we(d0_s_we), .s_cyc(d0_s_cyc),
    .s_stb(d0_s_stb), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .gnt(d0_gnt), .timeout(d0_timeout)
  );

  typedef struct {
    logic        is_err;
    logic        tmo;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b1;
  int   hold_viol;
  int   n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic is_err, input logic tmo, input logic chk,
                      input logic [31:0] dat);
    exp_t it;
    it.is_err = is_err; it.tmo = tmo; it.chk_dat = chk; it.dat = dat;
    if (id == 0) q0.push_back(it);
    else q1.push_back(it);
  endtask

  task automatic mon_pop(input int id, input logic e, input logic [31:0] d, input logic t);
    exp_t it;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_resp_m%0d: got ack/err=1 expected no response", id);
      return;
    end
    it = (id == 0) ? q0.pop_front() : q1.pop_front();
    $display("t=%0t m%0d resp err=%0b dat=0x%0h timeout=%0b", $time, id, e, d, t);
    check($sformatf("m%0d_resp_kind", id), e, it.is_err);
    check($sformatf("m%0d_timeout", id), t, it.tmo);
    if (it.chk_dat) check($sformatf("m%0d_dat_r", id), d, it.dat);
  endtask

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (m0_ack || m0_err) mon_pop(0, m0_err, m0_dat_r, timeout);
      if (m1_ack || m1_err) mon_pop(1, m1_err, m1_dat_r, timeout);
    end
  end

  task automatic start(input int id, input logic [31:0] adr);
    m_adr[id] = adr; m_dat_w[id] = adr + 1; m_sel[id] = 4'hF;
    m_we[id] = (id == 1); m_cyc[id] = 1'b1; m_stb[id] = 1'b1;
  endtask

  task automatic stop(input int id);
    m_cyc[id] = 1'b0; m_stb[id] = 1'b0;
  endtask

  task automatic wait_resp(input int id);
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (id == 0 ? (m0_ack || m0_err) : (m1_ack || m1_err)) return;
    end
    check($sformatf("wait_resp_m%0d", id), 0, 1);
  endtask

  task automatic burst(input int id, input logic [31:0] adr, input int beats);
    for (int b = 0; b < beats; b++) begin
      start(id, adr + 32'(4 * b));
      push(id, 1'b0, 1'b0, 1'b1, (adr + 32'(4 * b)) ^ PAT);
      wait_resp(id);
      @(posedge clock); #1;
    end
    stop(id);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat_w[i] = '0; m_sel[i] = '0; m_we[i] = 1'b0;
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
    end
    reset = 1'b1; slv_en = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_s_cyc", 32'(s_cyc), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_d0_gnt", 32'(d0_gnt), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single read: grant one cycle after cyc
    fork
      burst(0, 32'h100, 1);
      begin
        @(negedge clock);
        check("sr_gnt_first_cycle", 32'(gnt), 0);
        check("sr_s_cyc_first_cycle", 32'(s_cyc), 0);
        @(negedge clock);
        check("sr_gnt", 32'(gnt), 32'h1);
        check("sr_s_cyc", 32'(s_cyc), 1);
        check("sr_s_adr", s_adr, 32'h100);
        check("sr_s_we", 32'(s_we), 0);
        check("sr_s_sel", 32'(s_sel), 32'hF);
      end
    join
    idle(3);

    // Tie sequence after reset: m0, m1, m0
    do_reset();
    for (int r = 0; r < 3; r++) begin
      int w;
      w = r % 2;
      start(0, 32'h200 + 32'(16 * r));
      start(1, 32'h300 + 32'(16 * r));
      push(w, 1'b0, 1'b0, 1'b1, m_adr[w] ^ PAT);
      @(negedge clock);
      @(negedge clock);
      check($sformatf("tie%0d_gnt", r), 32'(gnt), (w == 1) ? 32'h2 : 32'h1);
      wait_resp(w);
      @(posedge clock); #1;
      stop(0); stop(1);
      idle(2);
      check($sformatf("tie%0d_release_gnt", r), 32'(gnt), 0);
    end

    // Ownership hold and handover
    fork
      burst(0, 32'h400, 4);
      begin @(posedge clock); #1; burst(1, 32'h500, 1); end
      begin
        hold_viol = 0;
        @(negedge clock);
        for (int n = 0; n < 200; n++) begin
          @(negedge clock);
          if (!m_cyc[0]) break;
          if (gnt != 2'b01) hold_viol++;
        end
        check("hold_violations", hold_viol, 0);
        check("hold_drop_s_cyc", 32'(s_cyc), 0);
        @(negedge clock);
        check("handover_gnt", 32'(gnt), 32'h2);
        check("handover_s_cyc", 32'(s_cyc), 1);
        check("handover_s_adr", s_adr, 32'h500);
        check("handover_s_we", 32'(s_we), 1);
        check("handover_s_dat_w", s_dat_w, 32'h501);
      end
    join
    idle(2);

    // Watchdog abort with TIMEOUT=8
    slv_en = 1'b0;
    fork
      begin
        start(1, 32'h600);
        push(1, 1'b1, 1'b1, 1'b0, '0);
        wait_resp(1);
        @(posedge clock); #1;
        stop(1);
      end
      begin @(posedge clock); @(posedge clock); #1; burst(0, 32'h700, 1); end
      begin
        repeat (9) @(negedge clock);
        check("wd_pre_m1_err", 32'(m1_err), 0);
        check("wd_pre_s_stb", 32'(s_stb), 1);
        @(negedge clock);
        check("wd_m1_err", 32'(m1_err), 1);
        check("wd_timeout", 32'(timeout), 1);
        check("wd_s_cyc", 32'(s_cyc), 0);
        check("wd_m0_err", 32'(m0_err), 0);
        @(posedge clock); #1;
        slv_en = 1'b1;
        @(negedge clock);
        check("wd_after_gnt", 32'(gnt), 0);
        check("wd_after_timeout", 32'(timeout), 0);
        @(negedge clock);
        check("wd_pending_gnt", 32'(gnt), 32'h1);
        check("wd_pending_s_adr", s_adr, 32'h700);
      end
    join
    idle(2);

    // Watchdog disabled (TIMEOUT=0 instance) under a 5000-cycle stall
    mon_en = 1'b0;
    do_reset();
    slv_en = 1'b0;
    start(0, 32'h800);
    n_bad = 0;
    repeat (5000) begin
      @(negedge clock);
      if (d0_m0_err || d0_m1_err || d0_timeout) n_bad++;
    end
    check("wd_off_err_events", n_bad, 0);
    check("wd_off_s_stb", 32'(d0_s_stb), 1);
    check("wd_off_gnt", 32'(d0_gnt), 32'h1);
    @(posedge clock); #1;
    stop(0);
    slv_en = 1'b1;
    do_reset();
    idle(1);
    mon_en = 1'b1;

    // Reset in the middle of an m1 burst
    start(1, 32'hA00);
    push(1, 1'b0, 1'b0, 1'b1, 32'hA00 ^ PAT);
    wait_resp(1);
    @(posedge clock); #1;
    start(1, 32'hA04);
    push(1, 1'b0, 1'b0, 1'b1, 32'hA04 ^ PAT);
    wait_resp(1);
    @(posedge clock); #1;
    start(1, 32'hA08);
    reset = 1'b1;
    @(negedge clock);
    check("rmb_gnt_before_edge", 32'(gnt), 32'h2);
    @(posedge clock); #1;
    reset = 1'b0;
    stop(1);
    @(negedge clock);
    check("rmb_gnt", 32'(gnt), 0);
    check("rmb_s_cyc", 32'(s_cyc), 0);
    @(posedge clock); #1;
    start(0, 32'hB00);
    start(1, 32'hB10);
    push(0, 1'b0, 1'b0, 1'b1, 32'hB00 ^ PAT);
    @(negedge clock);
    @(negedge clock);
    check("rmb_tie_gnt", 32'(gnt), 32'h1);
    wait_resp(0);
    @(posedge clock); #1;
    stop(0); stop(1);
    idle(3);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
